// File: rtl/fixed_dot_product_accumulator.sv
// fixed_dot_product_accumulator: sums IN_DEPTH signed partial dot products
// into one full-length result on a registered valid/ready output.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   data_in/_valid      signed partial sum in, with valid
//   data_in_ready       high when a partial sum can be accepted
//   data_out/_valid     registered signed sum of one group, with valid
//   data_out_ready      downstream accepts data_out
//
// Optional feature macro: FIXED_DOT_ACC_RELU_EN clamps negative results
// to zero on the way into data_out (accumulator is never clamped).
module fixed_dot_product_accumulator #(
    parameter int IN_WIDTH  = 34,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_WIDTH = IN_WIDTH + $clog2(IN_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_DEPTH - 1);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0] out_q, out_d;
    logic                        out_valid_q, out_valid_d;

    logic signed [OUT_WIDTH-1:0] in_ext;
    logic signed [OUT_WIDTH-1:0] base;
    logic signed [OUT_WIDTH-1:0] sum;
    logic signed [OUT_WIDTH-1:0] result;
    logic                        accept;

    assign in_ext         = OUT_WIDTH'($signed(data_in));
    assign data_in_ready  = !out_valid_q || data_out_ready;
    assign accept         = data_in_valid && data_in_ready;
    assign data_out       = out_q;
    assign data_out_valid = out_valid_q;

    // The first beat of a group loads rather than adds, so a stale
    // accumulator (aborted or finished group) can never leak in.
    always_comb begin
        base = (cnt_q == '0) ? '0 : acc_q;
        sum  = base + in_ext;
`ifdef FIXED_DOT_ACC_RELU_EN
        result = sum[OUT_WIDTH-1] ? '0 : sum;
`else
        result = sum;
`endif
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !data_out_ready;
        if (accept) begin
            if (cnt_q == LAST_CNT) begin
                // A consumed output and a new last beat in the same
                // cycle keep valid high: no bubble between groups.
                out_d       = result;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fixed_dot_product_accumulator.sv
// tb_fixed_dot_product_accumulator: table vectors, directed corner
// sequences and a randomized run against a queue-based group model.
module tb_fixed_dot_product_accumulator;

    localparam int IN_W = 34;
    localparam int D    = 4;
    localparam int OW   = 36;

    logic            clk = 1'b0;
    logic            rst;
    logic [IN_W-1:0] data_in;
    logic            data_in_valid;
    logic            data_in_ready;
    logic [OW-1:0]   data_out;
    logic            data_out_valid;
    logic            data_out_ready;

    int errors = 0;
    int checks = 0;

    fixed_dot_product_accumulator #(
        .IN_WIDTH (IN_W),
        .IN_DEPTH (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string  name;
        longint b[4];
        longint raw;
    } vec_t;

    vec_t tbl[7];

    function automatic longint clamp(input longint s);
`ifdef FIXED_DOT_ACC_RELU_EN
        return (s < 0) ? 64'sd0 : s;
`else
        return s;
`endif
    endfunction

    function automatic longint out_s();
        logic signed [OW-1:0] t;
        t = data_out;
        return longint'(t);
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input longint v);
        data_in       = IN_W'(v);
        data_in_valid = 1'b1;
        tick();
    endtask

    task automatic idle();
        data_in_valid = 1'b0;
        data_in       = '0;
        tick();
    endtask

    longint P33;
    longint grp[$];
    longint mval;
    logic   mv;
    logic   v;
    logic   r;
    logic   exp_rdy;
    logic [IN_W-1:0] rnd;
    int     groups;
    int     cyc;

    initial begin
        P33 = 64'sd1 <<< 33;
        tbl[0] = '{"plan_13",  '{5, -3, 10, 1}, 13};
        tbl[1] = '{"ones",     '{1, 1, 1, 1}, 4};
        tbl[2] = '{"neg_min",  '{-P33, -P33, -P33, -P33}, -(P33 * 4)};
        tbl[3] = '{"pos_max",  '{P33 - 1, P33 - 1, P33 - 1, P33 - 1},
                   P33 * 4 - 4};
        tbl[4] = '{"relu_neg", '{-5, 1, 1, 1}, -2};
        tbl[5] = '{"relu_pos", '{5, 1, 1, 1}, 8};
        tbl[6] = '{"zero",     '{0, 0, 0, 0}, 0};

        rst            = 1'b0;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        tick();
        chk("rst_valid", longint'(data_out_valid), 0);
        chk("rst_data", out_s(), 0);
        chk("rst_in_ready", longint'(data_in_ready), 1);
        tick();
        rst = 1'b1;
        tick();

        // Table vectors: valid exactly one cycle, after the last beat.
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < D; k++) begin
                beat(tbl[i].b[k]);
                if (k < D - 1)
                    chk({tbl[i].name, "_early"},
                        longint'(data_out_valid), 0);
            end
            chk({tbl[i].name, "_valid"}, longint'(data_out_valid), 1);
            chk({tbl[i].name, "_data"}, out_s(), clamp(tbl[i].raw));
            idle();
            chk({tbl[i].name, "_drop"}, longint'(data_out_valid), 0);
        end

        // Back-to-back groups with no bubble.
        for (int k = 0; k < 2 * D; k++) begin
            data_in       = (k < D) ? IN_W'(k + 1) : '1;
            data_in_valid = 1'b1;
            #0;
            chk("b2b_in_ready", longint'(data_in_ready), 1);
            tick();
            if (k == D - 1) begin
                chk("b2b_first", out_s(), clamp(10));
                chk("b2b_first_v", longint'(data_out_valid), 1);
            end
        end
        chk("b2b_second", out_s(), clamp(-4));
        chk("b2b_second_v", longint'(data_out_valid), 1);
        idle();

        // Backpressure: output held, input blocked, then release.
        data_out_ready = 1'b0;
        for (int k = 0; k < D; k++) beat(7);
        for (int k = 0; k < 5; k++) begin
            data_in       = IN_W'(2);
            data_in_valid = 1'b1;
            #0;
            chk("bp_in_ready", longint'(data_in_ready), 0);
            chk("bp_valid", longint'(data_out_valid), 1);
            chk("bp_hold", out_s(), clamp(28));
            tick();
        end
        data_out_ready = 1'b1;
        #0;
        chk("bp_release_rdy", longint'(data_in_ready), 1);
        tick();
        chk("bp_consumed", longint'(data_out_valid), 0);
        beat(3);
        beat(4);
        beat(5);
        chk("bp_next_v", longint'(data_out_valid), 1);
        chk("bp_next", out_s(), clamp(14));
        idle();

        // Reset mid-group: partial beats are discarded.
        beat(9);
        beat(9);
        data_in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_valid", longint'(data_out_valid), 0);
        chk("arst_data", out_s(), 0);
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < D; k++) beat(1);
        chk("arst_after_v", longint'(data_out_valid), 1);
        chk("arst_after", out_s(), clamp(4));
        idle();
        idle();

        // Randomized run against a group-level model.
        mv     = 1'b0;
        mval   = 0;
        groups = 0;
        cyc    = 0;
        grp.delete();
        while (groups < 40 && cyc < 3000) begin
            chk("rnd_valid", longint'(data_out_valid), longint'(mv));
            if (mv) chk("rnd_data", out_s(), mval);
            v   = ($urandom_range(3, 0) != 0);
            r   = ($urandom_range(2, 0) != 0);
            rnd = {2'($urandom_range(3, 0)), 32'($urandom)};
            if ($urandom_range(7, 0) == 0)
                rnd = {1'b1, {(IN_W - 1){1'b0}}};
            data_in        = rnd;
            data_in_valid  = v;
            data_out_ready = r;
            exp_rdy        = !mv || r;
            #0;
            chk("rnd_in_ready", longint'(data_in_ready), longint'(exp_rdy));
            if (mv && r) mv = 1'b0;
            if (v && exp_rdy) begin
                grp.push_back(longint'($signed(rnd)));
                if (grp.size() == D) begin
                    mval = 0;
                    foreach (grp[j]) mval += grp[j];
                    mval = clamp(mval);
                    mv   = 1'b1;
                    grp.delete();
                    groups++;
                end
            end
            tick();
            cyc++;
        end
        if (groups < 40) begin
            errors++;
            $display("FAIL rnd_budget: got %0d groups expected 40", groups);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
